// File: rtl/lfsr_checker_if.sv
// rtl/lfsr_checker_if.sv - stream input and status outputs of the LFSR checker
interface lfsr_checker_if #(
  parameter int CNTW = 16
);
  logic            in_val;
  logic            in_bit;
  logic            clr_cnt;
  logic            locked;
  logic            err_pulse;
  logic            lost_pulse;
  logic [CNTW-1:0] err_cnt;
  logic [CNTW-1:0] bit_cnt;

  modport master (
    output in_val, in_bit, clr_cnt,
    input  locked, err_pulse, lost_pulse, err_cnt, bit_cnt
  );

  modport slave (
    input  in_val, in_bit, clr_cnt,
    output locked, err_pulse, lost_pulse, err_cnt, bit_cnt
  );
endinterface

// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - self-synchronising LFSR sequence checker with windowed loss detection
module lfsr_checker #(
  parameter int               NBITS       = 8,
  parameter logic [NBITS-1:0] TAPS        = 8'hB8,
  parameter int               CNTW        = 16,
  parameter int               WINDOW      = 64,
  parameter int               LOSS_THRESH = 8
) (
  input  logic          clk,
  input  logic          rst,
  lfsr_checker_if.slave bus
);
  typedef enum logic {ACQUIRE = 1'b0, CHECK = 1'b1} state_t;

  localparam int AW  = $clog2(NBITS + 1);
  localparam int WCW = $clog2(WINDOW);
  localparam int WEW = $clog2(LOSS_THRESH + 1);

  localparam logic [AW-1:0]  ACQ_LAST = AW'(NBITS - 1);
  localparam logic [WCW-1:0] WIN_LAST = WCW'(WINDOW - 1);
  localparam logic [WEW-1:0] ERR_LOSS = WEW'(LOSS_THRESH);

  state_t           state, state_n;
  logic [NBITS-1:0] r, r_n;
  logic [AW-1:0]    acq_cnt, acq_n;
  logic [WCW-1:0]   win_cnt, win_cnt_n;
  logic [WEW-1:0]   win_err, win_err_n;
  logic [CNTW-1:0]  err_cnt, err_cnt_n;
  logic [CNTW-1:0]  bit_cnt, bit_cnt_n;
  logic             err_pulse, err_pulse_n;
  logic             lost_pulse, lost_pulse_n;

  logic [NBITS-1:0] r_acq;
  logic             expected;
  logic             mismatch;
  logic [WEW-1:0]   win_err_inc;

  assign r_acq       = {r[NBITS-2:0], bus.in_bit};
  assign expected    = ^(r & TAPS);
  assign mismatch    = bus.in_bit ^ expected;
  assign win_err_inc = win_err + WEW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ACQUIRE;
      r          <= '0;
      acq_cnt    <= '0;
      win_cnt    <= '0;
      win_err    <= '0;
      err_cnt    <= '0;
      bit_cnt    <= '0;
      err_pulse  <= 1'b0;
      lost_pulse <= 1'b0;
    end else begin
      state      <= state_n;
      r          <= r_n;
      acq_cnt    <= acq_n;
      win_cnt    <= win_cnt_n;
      win_err    <= win_err_n;
      err_cnt    <= err_cnt_n;
      bit_cnt    <= bit_cnt_n;
      err_pulse  <= err_pulse_n;
      lost_pulse <= lost_pulse_n;
    end
  end

  always_comb begin
    state_n      = state;
    r_n          = r;
    acq_n        = acq_cnt;
    win_cnt_n    = win_cnt;
    win_err_n    = win_err;
    err_cnt_n    = err_cnt;
    bit_cnt_n    = bit_cnt;
    err_pulse_n  = 1'b0;
    lost_pulse_n = 1'b0;

    if (bus.in_val) begin
      if (state == ACQUIRE) begin
        r_n = r_acq;
        if (acq_cnt == ACQ_LAST) begin
          acq_n = '0;
          // An all-zero seed would predict zeros forever, so keep acquiring.
          if (r_acq != '0) begin
            state_n   = CHECK;
            win_cnt_n = '0;
            win_err_n = '0;
          end
        end else begin
          acq_n = acq_cnt + AW'(1);
        end
      end else begin
        // Shift the prediction, not the received bit, so one error stays isolated.
        r_n = {r[NBITS-2:0], expected};
        if (bit_cnt != '1) bit_cnt_n = bit_cnt + CNTW'(1);
        if (mismatch) begin
          err_pulse_n = 1'b1;
          if (err_cnt != '1) err_cnt_n = err_cnt + CNTW'(1);
        end
        if (mismatch && (win_err_inc == ERR_LOSS)) begin
          state_n      = ACQUIRE;
          lost_pulse_n = 1'b1;
          r_n          = '0;
          acq_n        = '0;
          win_cnt_n    = '0;
          win_err_n    = '0;
        end else if (win_cnt == WIN_LAST) begin
          win_cnt_n = '0;
          win_err_n = '0;
        end else begin
          win_cnt_n = win_cnt + WCW'(1);
          if (mismatch) win_err_n = win_err_inc;
        end
      end
    end

    if (bus.clr_cnt) begin
      err_cnt_n = '0;
      bit_cnt_n = '0;
    end
  end

  assign bus.locked     = (state == CHECK);
  assign bus.err_pulse  = err_pulse;
  assign bus.lost_pulse = lost_pulse;
  assign bus.err_cnt    = err_cnt;
  assign bus.bit_cnt    = bit_cnt;
endmodule

// File: tb/tb_lfsr_checker.sv
// tb/tb_lfsr_checker.sv - randomized bench for lfsr_checker against a generator-level model
module tb_lfsr_checker;
  logic clk;
  logic rst;

  lfsr_checker_if #(.CNTW(16)) i1 ();
  lfsr_checker_if #(.CNTW(4))  i2 ();

  assign i2.in_val  = i1.in_val;
  assign i2.in_bit  = i1.in_bit;
  assign i2.clr_cnt = i1.clr_cnt;

  lfsr_checker #(.NBITS(8), .TAPS(8'hB8), .CNTW(16), .WINDOW(64), .LOSS_THRESH(8)) u1 (
    .clk(clk), .rst(rst), .bus(i1.slave)
  );
  lfsr_checker #(.NBITS(8), .TAPS(8'hB8), .CNTW(4), .WINDOW(64), .LOSS_THRESH(64)) u2 (
    .clk(clk), .rst(rst), .bus(i2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       lk;
    bit [7:0] hist;
    int       acq;
    bit [7:0] g;
    int       wc;
    int       we;
    int       ec;
    int       bc;
    bit       ep;
    bit       lp;
  } model_t;

  model_t m1 = '{default: 0};
  model_t m2 = '{default: 0};
  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  function automatic bit [7:0] gen_step(input bit [7:0] s);
    return {s[6:0], ^(s & 8'hB8)};
  endfunction

  // Reference: after lock, run a generator advanced 8 steps past the captured seed.
  function automatic model_t mstep(input model_t mi, input bit r, input bit v, input bit b,
                                   input bit c, input int cmax, input int thr);
    model_t m;
    bit e;
    m = mi;
    if (r) begin
      m = '{default: 0};
      return m;
    end
    m.ep = 1'b0;
    m.lp = 1'b0;
    if (v) begin
      if (!m.lk) begin
        m.hist = {m.hist[6:0], b};
        m.acq++;
        if (m.acq == 8) begin
          m.acq = 0;
          if (m.hist != 8'h00) begin
            m.lk = 1'b1;
            m.g  = m.hist;
            for (int k = 0; k < 8; k++) m.g = gen_step(m.g);
            m.wc = 0;
            m.we = 0;
          end
        end
      end else begin
        e   = m.g[7];
        m.g = gen_step(m.g);
        if (m.bc < cmax) m.bc++;
        if (b != e) begin
          if (m.ec < cmax) m.ec++;
          m.ep = 1'b1;
          m.we++;
        end
        m.wc++;
        if (m.we == thr) begin
          m.lk = 1'b0; m.lp = 1'b1; m.acq = 0; m.hist = 8'h00; m.wc = 0; m.we = 0;
        end else if (m.wc == 64) begin
          m.wc = 0; m.we = 0;
        end
      end
    end
    if (c) begin
      m.ec = 0;
      m.bc = 0;
    end
    return m;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  always @(posedge clk) begin
    m1 = mstep(m1, rst, i1.in_val, i1.in_bit, i1.clr_cnt, 65535, 8);
    m2 = mstep(m2, rst, i1.in_val, i1.in_bit, i1.clr_cnt, 15, 64);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("u1.locked",     i1.locked,     m1.lk);
      check("u1.err_pulse",  i1.err_pulse,  m1.ep);
      check("u1.lost_pulse", i1.lost_pulse, m1.lp);
      check("u1.err_cnt",    i1.err_cnt,    m1.ec);
      check("u1.bit_cnt",    i1.bit_cnt,    m1.bc);
      check("u2.locked",     i2.locked,     m2.lk);
      check("u2.err_pulse",  i2.err_pulse,  m2.ep);
      check("u2.lost_pulse", i2.lost_pulse, m2.lp);
      check("u2.err_cnt",    i2.err_cnt,    m2.ec);
      check("u2.bit_cnt",    i2.bit_cnt,    m2.bc);
    end
  end

  task automatic cyc(input bit v, input bit b, input bit c);
    i1.in_val  = v;
    i1.in_bit  = b;
    i1.clr_cnt = c;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic send_byte(input bit [7:0] w);
    for (int i = 7; i >= 0; i--) cyc(1'b1, w[i], 1'b0);
  endtask

  bit [7:0] g;
  int       n;
  int       ep_cnt;
  bit       lost;
  int       burst;

  initial begin
    rst = 1'b1;
    i1.in_val = 1'b0; i1.in_bit = 1'b0; i1.clr_cnt = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("rst_locked",  i1.locked,  0);
    check("rst_err_cnt", i1.err_cnt, 0);
    check("rst_bit_cnt", i1.bit_cnt, 0);
    rst = 1'b0;

    // 8'h80 seed: locks after exactly 8 bits, next expected bit is 1
    for (int i = 0; i < 7; i++) cyc(1'b1, (i == 0), 1'b0);
    check("acq_7_bits_unlocked", i1.locked, 0);
    cyc(1'b1, 1'b0, 1'b0);
    check("acq_8_bits_locked", i1.locked, 1);
    cyc(1'b1, 1'b1, 1'b0);
    check("first_bit_err_cnt", i1.err_cnt, 0);
    check("first_bit_bit_cnt", i1.bit_cnt, 1);
    check("model_first_bit_cnt", m1.bc, 1);

    // 1000 clean bits with random gaps
    do_reset();
    g = 8'h01;
    repeat (8) begin cyc(1'b1, g[7], 1'b0); g = gen_step(g); end
    n = 0;
    while (n < 1000) begin
      if ($urandom_range(3) == 0) cyc(1'b0, 1'($urandom_range(1)), 1'b0);
      else begin cyc(1'b1, g[7], 1'b0); g = gen_step(g); n++; end
    end
    check("clean_bit_cnt", i1.bit_cnt, 1000);
    check("clean_err_cnt", i1.err_cnt, 0);
    check("clean_locked",  i1.locked,  1);

    // three isolated bit flips
    ep_cnt = 0;
    for (int k = 0; k < 80; k++) begin
      cyc(1'b1, g[7] ^ (k == 20 || k == 40 || k == 60), 1'b0);
      g = gen_step(g);
      if (i1.err_pulse) ep_cnt++;
    end
    check("flip_pulses",  ep_cnt,     3);
    check("flip_err_cnt", i1.err_cnt, 3);
    check("flip_locked",  i1.locked,  1);

    // constant zero input drops lock, zero seed rejected, then relock
    lost = 1'b0;
    for (int k = 0; k < 200 && !lost; k++) begin
      cyc(1'b1, 1'b0, 1'b0);
      if (i1.lost_pulse) begin
        lost = 1'b1;
        check("lost_with_locked_low", i1.locked, 0);
      end
    end
    check("loss_seen", lost, 1);
    send_byte(8'h00);
    check("zero_seed_rejected", i1.locked, 0);
    send_byte(8'hA5);
    check("relock_after_loss", i1.locked, 1);

    // saturation on the 4-bit counter instance, then clear with a mismatch
    do_reset();
    g = 8'hA5;
    repeat (8) begin cyc(1'b1, g[7], 1'b0); g = gen_step(g); end
    repeat (20) begin cyc(1'b1, ~g[7], 1'b0); g = gen_step(g); end
    check("sat_err_cnt", i2.err_cnt, 15);
    check("sat_bit_cnt", i2.bit_cnt, 15);
    check("sat_locked",  i2.locked,  1);
    cyc(1'b1, ~g[7], 1'b1);
    g = gen_step(g);
    check("clr_err_cnt",   i2.err_cnt,   0);
    check("clr_err_pulse", i2.err_pulse, 1);

    // reset mid-CHECK with in_val high
    do_reset();
    g = 8'h3C;
    repeat (13) begin cyc(1'b1, g[7], 1'b0); g = gen_step(g); end
    check("pre_rst_locked", i1.locked, 1);
    rst = 1'b1;
    cyc(1'b1, ~g[7], 1'b1);
    rst = 1'b0;
    check("midrst_locked",  i1.locked,  0);
    check("midrst_bit_cnt", i1.bit_cnt, 0);
    check("midrst_err_cnt", i1.err_cnt, 0);
    check("midrst_pulses",  {i1.err_pulse, i1.lost_pulse}, 0);
    g = 8'h5A;
    repeat (7) begin cyc(1'b1, g[7], 1'b0); g = gen_step(g); end
    check("relock_7_unlocked", i1.locked, 0);
    cyc(1'b1, g[7], 1'b0);
    g = gen_step(g);
    check("relock_8_locked", i1.locked, 1);

    // randomized traffic: gaps, isolated errors, error bursts, clears, resets, resyncs
    burst = 0;
    for (int k = 0; k < 4000; k++) begin
      bit v, b, c;
      v = ($urandom_range(4) != 0);
      c = ($urandom_range(59) == 0);
      if ($urandom_range(299) == 0) burst = 30;
      if ($urandom_range(499) == 0) g = 8'($urandom_range(255));
      b = g[7] ^ ($urandom_range(39) == 0);
      if (burst > 0) begin b = 1'($urandom_range(1)); burst--; end
      rst = ($urandom_range(699) == 0);
      cyc(v, b, c);
      rst = 1'b0;
      if (v) g = gen_step(g);
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Receive-side companion to the LFSR generator. It takes the generator's serial output stream one bit per accepted cycle, self-synchronises its own copy of the LFSR state from the incoming bits, then predicts every following bit and counts mismatches. It reports lock status and saturating error and bit counters, and drops lock when the error density in a sliding check window shows the stream is no longer the expected sequence.

## Interface
- NBITS, 8: LFSR width; also the number of bits needed to acquire.
- TAPS, 8'hB8: feedback tap mask, NBITS wide; the generator must use the same mask.
- CNTW, 16: width of err_cnt and bit_cnt.
- WINDOW, 64: length of the loss-detection window, in checked bits; must be ≥2.
- LOSS_THRESH, 8: number of mismatches inside one window that forces loss of lock; 1 ≤ LOSS_THRESH ≤ WINDOW.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_val  input  1  in_bit is valid and consumed on this edge.
- in_bit  input  1  received stream bit.
- clr_cnt  input  1  clear err_cnt and bit_cnt.
- locked  output  1  high while in CHECK.
- err_pulse  output  1  one-cycle pulse for each mismatched checked bit.
- lost_pulse  output  1  one-cycle pulse when lock is dropped.
- err_cnt  output  CNTW  saturating mismatch count.
- bit_cnt  output  CNTW  saturating count of checked bits.

## Operation
- Generator model: state s; output bit = s[NBITS-1]; next s = {s[NBITS-2:0], ^(s & TAPS)}.
- Internal shift register r (NBITS). On each accepted bit, r shifts left and the new bit enters r[0].
- Expected next bit = ^(r & TAPS).
- States: ACQUIRE (reset state) and CHECK.
- ACQUIRE:
  - Each accepted in_bit shifts into r; acq_cnt increments. No comparison is made and no counter changes.
  - On the NBITS-th accepted bit, the next r is examined:
    - Nonzero: go to CHECK and clear the window counters.
    - All zero (degenerate LFSR state): stay in ACQUIRE, set acq_cnt = 0, and keep shifting.
- CHECK:
  - Each accepted bit is compared with the expected bit.
  - r shifts in the *expected* bit, not the received one, so a single bit error does not propagate.
  - bit_cnt increments.
  - On mismatch: err_cnt increments, err_pulse is asserted, and win_err increments.
- Window: win_cnt counts checked bits from 0 to WINDOW-1.
  - When the WINDOW-th bit is checked, win_cnt and win_err return to 0.
  - If a check brings win_err to LOSS_THRESH: go to ACQUIRE, assert lost_pulse, and set r = 0, acq_cnt = 0, win_cnt = 0, win_err = 0.
  - Loss takes priority over the window-end reset on the same bit.
- Counters saturate at 2^CNTW-1; they never wrap.
- clr_cnt:
  - err_cnt and bit_cnt become 0 on that edge, and clr_cnt takes priority over any increment on the same edge.
  - The bit on that edge is still checked: err_pulse, window and loss logic all act normally.
  - Lock state is not affected.
- in_val = 0: no state, counter or r change, and pulses are low.

## Timing
- Reset values: locked = 0, err_pulse = 0, lost_pulse = 0, err_cnt = 0, bit_cnt = 0, state ACQUIRE, r = 0, acq_cnt = 0, win_cnt = 0, win_err = 0.
- rst overrides all inputs, including in_val and clr_cnt.
- Reset mid-CHECK forces a full reacquisition: NBITS fresh bits are needed.
- All outputs are registered; no combinational path from input to output.
- locked rises in the cycle after the edge that accepts the NBITS-th acquire bit. The earliest lock from reset is NBITS accepted bits.
- The first compared bit is the next accepted bit after lock.
- err_pulse is high for exactly the one cycle after the edge that sampled the mismatched bit.
- err_cnt updates on that same edge, i.e. it is visible together with err_pulse.
- lost_pulse and the fall of locked appear in the same cycle.
- The bit that triggers loss is counted: err_cnt, bit_cnt and err_pulse all update.
- Back-to-back in_val is supported with no bubbles; throughput is 1 bit per cycle.

## Test plan
- Reset, then feed 8'h80 MSB-first (1,0,0,0,0,0,0,0) → locked = 1 the cycle after the 8th bit. The next expected bit is ^(8'h80 & 8'hB8) = 1; sending 1 leaves err_cnt = 0 and bit_cnt = 1.
- Lock from a reference LFSR seeded 8'h01, then run 1000 clean bits with random in_val gaps → err_cnt = 0, bit_cnt = 1000, locked stays 1, no pulses.
- After lock, flip 3 isolated bits at least 10 bits apart → exactly 3 err_pulses, err_cnt = 3, locked remains 1, and the stream stays in sync afterward with no further errors.
- After lock, switch the input to a constant 0 → lost_pulse in the same cycle that locked falls, once win_err hits 8. Then 8 zeros → still ACQUIRE (all-zero seed rejected). Then 8 bits of a valid LFSR state → relock.
- Force err_cnt to its limit using CNTW = 4 and 20 errors, with LOSS_THRESH = WINDOW = 64 → err_cnt holds at 15. Then clr_cnt together with a mismatch → err_cnt = 0, err_pulse = 1.
- Assert rst mid-CHECK while in_val = 1 → all outputs and counters are 0 next cycle, locked = 0, and relock takes exactly 8 accepted bits.
